// File: rtl/node_mu_search.sv
// node_mu_search: minimisation (mu-operator) node for the recursive-function tree.
// Finds the least y >= 0 such that the child g(x0, x1, y) returns 0.
// The child is driven through the ST/RD/RES handshake; the same handshake is presented upstream.
// Optional search limit with ERR output: define NODE_MU_LIMIT_EN.
module node_mu_search #(
    parameter int unsigned WIDTH    = 16
`ifdef NODE_MU_LIMIT_EN
    ,
    parameter int unsigned MAX_ITER = 16'hFFFF
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ST,
    output logic             RD,
    output logic [WIDTH-1:0] RES,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    output logic             CST,
    input  logic             CRD,
    input  logic [WIDTH-1:0] CRES,
    output logic [WIDTH-1:0] CIN0,
    output logic [WIDTH-1:0] CIN1,
    output logic [WIDTH-1:0] CIN2
`ifdef NODE_MU_LIMIT_EN
    ,
    output logic             ERR
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_LO,
        S_WAIT_HI
    } state_t;

`ifdef NODE_MU_LIMIT_EN
    localparam logic [WIDTH-1:0] MAX_Y = WIDTH'(MAX_ITER);
`endif

    state_t           state_q, state_d;
    logic             st_old_q;
    logic             rd_q, rd_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] x0_q, x0_d;
    logic [WIDTH-1:0] x1_q, x1_d;
`ifdef NODE_MU_LIMIT_EN
    logic             err_q, err_d;
`endif
    logic             start;

    // A new search begins on a rising edge of ST, in any state.
    assign start = ST && !st_old_q;

    // State and datapath registers; ST history is tracked even during reset
    // so a start held high across reset does not launch a search afterwards.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, regardless of statement order.
        st_old_q <= ST;
        if (!RST) begin
            state_q <= S_IDLE;
            rd_q    <= 1'b1;
            res_q   <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
`ifdef NODE_MU_LIMIT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
`ifdef NODE_MU_LIMIT_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and datapath update; a start edge overrides any search in progress.
    always_comb begin
        // NOTE: every variable gets a hold-value default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        rd_d    = rd_q;
        res_d   = res_q;
        y_d     = y_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
`ifdef NODE_MU_LIMIT_EN
        err_d   = err_q;
`endif
        if (start) begin
            x0_d    = IN0;
            x1_d    = IN1;
            y_d     = '0;
            rd_d    = 1'b0;
`ifdef NODE_MU_LIMIT_EN
            err_d   = 1'b0;
`endif
            state_d = S_LAUNCH;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_IDLE;
                S_LAUNCH:  state_d = S_WAIT_LO;
                // Child drops ready once it has taken the start.
                S_WAIT_LO: if (!CRD) state_d = S_WAIT_HI;
                S_WAIT_HI: begin
                    if (CRD) begin
                        if (CRES == '0) begin
                            res_d   = y_q;
                            rd_d    = 1'b1;
                            state_d = S_IDLE;
`ifdef NODE_MU_LIMIT_EN
                        end else if (y_q == MAX_Y) begin
                            res_d   = '1;
                            err_d   = 1'b1;
                            rd_d    = 1'b1;
                            state_d = S_IDLE;
`endif
                        end else begin
                            // Without a limit y wraps and the search runs on forever.
                            y_d     = y_q + 1'b1;
                            state_d = S_LAUNCH;
                        end
                    end
                end
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Outputs: child start is a one-clock pulse in LAUNCH; arguments come straight from registers.
    always_comb begin
        CST  = (state_q == S_LAUNCH);
        RD   = rd_q;
        RES  = res_q;
        CIN0 = x0_q;
        CIN1 = x1_q;
        CIN2 = y_q;
`ifdef NODE_MU_LIMIT_EN
        ERR  = err_q;
`endif
    end

endmodule
